// File: rtl/ex_mem_reg.sv
// ex_mem_reg: dual-issue EX->MEM pipeline register with a load-use interlock.
// Latency: 1 cycle from EX inputs to MEM outputs. EX_stall is combinational.
// Backpressure: MEM_stall holds every MEM register. A hazard inserts one MEM bubble and holds EX.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   EX_*                     issue-slot A/B fields at the end of EX, plus EX source registers
//   EX_kill_b                drop slot B of the current bundle (A mispredicted)
//   flush_all                clear MEM valid/we (exception or ertn)
//   MEM_stall                hold the MEM stage
//   MEM_*                    registered slot fields consumed by MEM and the forwarding network
//   EX_stall                 hold EX and everything upstream this cycle
//   interlock_cnt            saturating count of load-use interlock cycles
module ex_mem_reg #(
  parameter int SEL_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             EX_valid_a,
  input  logic             EX_valid_b,
  input  logic [4:0]       EX_rf_waddr_a,
  input  logic [4:0]       EX_rf_waddr_b,
  input  logic             EX_rf_we_a,
  input  logic             EX_rf_we_b,
  input  logic [SEL_W-1:0] EX_wb_mux_select_b,
  input  logic [31:0]      EX_alu_result_a,
  input  logic [31:0]      EX_alu_result_b,
  input  logic [31:0]      EX_pc_a,
  input  logic [31:0]      EX_pc_b,
  input  logic [4:0]       EX_rf_raddr_a1,
  input  logic [4:0]       EX_rf_raddr_a2,
  input  logic [4:0]       EX_rf_raddr_b1,
  input  logic [4:0]       EX_rf_raddr_b2,
  input  logic             EX_kill_b,
  input  logic             flush_all,
  input  logic             MEM_stall,
  output logic             MEM_valid_a,
  output logic             MEM_valid_b,
  output logic [4:0]       MEM_rf_waddr_a,
  output logic [4:0]       MEM_rf_waddr_b,
  output logic             MEM_rf_we_a,
  output logic             MEM_rf_we_b,
  output logic [SEL_W-1:0] MEM_wb_mux_select_b,
  output logic [31:0]      MEM_alu_result_a,
  output logic [31:0]      MEM_alu_result_b,
  output logic [31:0]      MEM_pc_a,
  output logic [31:0]      MEM_pc_b,
  output logic             EX_stall,
  output logic [31:0]      interlock_cnt
);

  logic             valid_a_q, valid_a_d, valid_b_q, valid_b_d;
  logic             we_a_q, we_a_d, we_b_q, we_b_d;
  logic [4:0]       waddr_a_q, waddr_a_d, waddr_b_q, waddr_b_d;
  logic [SEL_W-1:0] sel_b_q, sel_b_d;
  logic [31:0]      res_a_q, res_a_d, res_b_q, res_b_d;
  logic [31:0]      pc_a_q, pc_a_d, pc_b_q, pc_b_d;
  logic [31:0]      cnt_q, cnt_d;

  logic src_hit_a, src_hit_b, hz, load_data;

  // Only slot B can carry a non-ALU result (load/MUL/DIV); slot A in MEM is
  // always forwardable. A stalled MEM stage cannot retire its producer, so the
  // hazard is masked and re-evaluated when the stall releases.
  assign src_hit_a = EX_valid_a &
                     ((EX_rf_raddr_a1 == waddr_b_q) | (EX_rf_raddr_a2 == waddr_b_q));
  assign src_hit_b = EX_valid_b &
                     ((EX_rf_raddr_b1 == waddr_b_q) | (EX_rf_raddr_b2 == waddr_b_q));
  assign hz        = we_b_q & ~sel_b_q[0] & (src_hit_a | src_hit_b) & ~MEM_stall;
  assign EX_stall  = MEM_stall | hz;

  // Payload fields are don't-care when their valid is 0, so they simply follow
  // EX whenever MEM is not held (this includes flush and bubble cycles).
  assign load_data = flush_all | ~MEM_stall;

  always_comb begin
    valid_a_d = valid_a_q;
    valid_b_d = valid_b_q;
    we_a_d    = we_a_q;
    we_b_d    = we_b_q;
    waddr_a_d = waddr_a_q;
    waddr_b_d = waddr_b_q;
    sel_b_d   = sel_b_q;
    res_a_d   = res_a_q;
    res_b_d   = res_b_q;
    pc_a_d    = pc_a_q;
    pc_b_d    = pc_b_q;
    cnt_d     = cnt_q;

    if (load_data) begin
      waddr_a_d = EX_rf_waddr_a;
      waddr_b_d = EX_rf_waddr_b;
      sel_b_d   = EX_wb_mux_select_b;
      res_a_d   = EX_alu_result_a;
      res_b_d   = EX_alu_result_b;
      pc_a_d    = EX_pc_a;
      pc_b_d    = EX_pc_b;
    end

    if (flush_all || (!MEM_stall && hz)) begin
      // flush, or a bubble while EX is held
      valid_a_d = 1'b0;
      valid_b_d = 1'b0;
      we_a_d    = 1'b0;
      we_b_d    = 1'b0;
    end else if (!MEM_stall) begin
      valid_a_d = EX_valid_a;
      valid_b_d = EX_valid_b & ~EX_kill_b;
      we_a_d    = EX_rf_we_a & valid_a_d;
      we_b_d    = EX_rf_we_b & valid_b_d;
    end

    // Saturating: never wraps back to zero.
    if (hz && !flush_all && !(&cnt_q)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_a_q <= 1'b0;
      valid_b_q <= 1'b0;
      we_a_q    <= 1'b0;
      we_b_q    <= 1'b0;
      waddr_a_q <= '0;
      waddr_b_q <= '0;
      sel_b_q   <= '0;
      res_a_q   <= '0;
      res_b_q   <= '0;
      pc_a_q    <= '0;
      pc_b_q    <= '0;
      cnt_q     <= '0;
    end else begin
      valid_a_q <= valid_a_d;
      valid_b_q <= valid_b_d;
      we_a_q    <= we_a_d;
      we_b_q    <= we_b_d;
      waddr_a_q <= waddr_a_d;
      waddr_b_q <= waddr_b_d;
      sel_b_q   <= sel_b_d;
      res_a_q   <= res_a_d;
      res_b_q   <= res_b_d;
      pc_a_q    <= pc_a_d;
      pc_b_q    <= pc_b_d;
      cnt_q     <= cnt_d;
    end
  end

  assign MEM_valid_a         = valid_a_q;
  assign MEM_valid_b         = valid_b_q;
  assign MEM_rf_waddr_a      = waddr_a_q;
  assign MEM_rf_waddr_b      = waddr_b_q;
  assign MEM_rf_we_a         = we_a_q;
  assign MEM_rf_we_b         = we_b_q;
  assign MEM_wb_mux_select_b = sel_b_q;
  assign MEM_alu_result_a    = res_a_q;
  assign MEM_alu_result_b    = res_b_q;
  assign MEM_pc_a            = pc_a_q;
  assign MEM_pc_b            = pc_b_q;
  assign interlock_cnt       = cnt_q;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Bench for ex_mem_reg: directed vectors, a behavioural model of the MEM
// stage contents checked every cycle, and literal expectations per scenario.
module tb_ex_mem_reg;

  logic        clk;
  logic        rst;
  logic        EX_valid_a, EX_valid_b;
  logic [4:0]  EX_rf_waddr_a, EX_rf_waddr_b;
  logic        EX_rf_we_a, EX_rf_we_b;
  logic [8:0]  EX_wb_mux_select_b;
  logic [31:0] EX_alu_result_a, EX_alu_result_b, EX_pc_a, EX_pc_b;
  logic [4:0]  EX_rf_raddr_a1, EX_rf_raddr_a2, EX_rf_raddr_b1, EX_rf_raddr_b2;
  logic        EX_kill_b, flush_all, MEM_stall;
  logic        MEM_valid_a, MEM_valid_b;
  logic [4:0]  MEM_rf_waddr_a, MEM_rf_waddr_b;
  logic        MEM_rf_we_a, MEM_rf_we_b;
  logic [8:0]  MEM_wb_mux_select_b;
  logic [31:0] MEM_alu_result_a, MEM_alu_result_b, MEM_pc_a, MEM_pc_b;
  logic        EX_stall;
  logic [31:0] interlock_cnt;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  ex_mem_reg #(.SEL_W(9)) dut (
    .clk(clk), .rst(rst),
    .EX_valid_a(EX_valid_a), .EX_valid_b(EX_valid_b),
    .EX_rf_waddr_a(EX_rf_waddr_a), .EX_rf_waddr_b(EX_rf_waddr_b),
    .EX_rf_we_a(EX_rf_we_a), .EX_rf_we_b(EX_rf_we_b),
    .EX_wb_mux_select_b(EX_wb_mux_select_b),
    .EX_alu_result_a(EX_alu_result_a), .EX_alu_result_b(EX_alu_result_b),
    .EX_pc_a(EX_pc_a), .EX_pc_b(EX_pc_b),
    .EX_rf_raddr_a1(EX_rf_raddr_a1), .EX_rf_raddr_a2(EX_rf_raddr_a2),
    .EX_rf_raddr_b1(EX_rf_raddr_b1), .EX_rf_raddr_b2(EX_rf_raddr_b2),
    .EX_kill_b(EX_kill_b), .flush_all(flush_all), .MEM_stall(MEM_stall),
    .MEM_valid_a(MEM_valid_a), .MEM_valid_b(MEM_valid_b),
    .MEM_rf_waddr_a(MEM_rf_waddr_a), .MEM_rf_waddr_b(MEM_rf_waddr_b),
    .MEM_rf_we_a(MEM_rf_we_a), .MEM_rf_we_b(MEM_rf_we_b),
    .MEM_wb_mux_select_b(MEM_wb_mux_select_b),
    .MEM_alu_result_a(MEM_alu_result_a), .MEM_alu_result_b(MEM_alu_result_b),
    .MEM_pc_a(MEM_pc_a), .MEM_pc_b(MEM_pc_b),
    .EX_stall(EX_stall), .interlock_cnt(interlock_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of what the MEM stage holds.
  logic        m_va, m_vb, m_wea, m_web;
  logic [4:0]  m_wa, m_wb;
  logic [8:0]  m_sel;
  logic [31:0] m_ra, m_rb, m_pa, m_pb, m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // A live EX source needs a value that only appears after MEM (non-ALU B result).
  function automatic bit model_hz();
    logic [4:0] srcs[$];
    if (EX_valid_a) begin srcs.push_back(EX_rf_raddr_a1); srcs.push_back(EX_rf_raddr_a2); end
    if (EX_valid_b) begin srcs.push_back(EX_rf_raddr_b1); srcs.push_back(EX_rf_raddr_b2); end
    if (!m_web || m_sel[0] || MEM_stall) return 1'b0;
    foreach (srcs[i]) if (srcs[i] == m_wb) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    bit h;
    if (rst) begin
      {m_va, m_vb, m_wea, m_web} = '0;
      m_wa = '0; m_wb = '0; m_sel = '0;
      m_ra = '0; m_rb = '0; m_pa = '0; m_pb = '0; m_cnt = '0;
    end else begin
      h = model_hz();
      if (h && !flush_all && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      if (flush_all || (!MEM_stall && !h)) begin
        m_wa = EX_rf_waddr_a; m_wb = EX_rf_waddr_b; m_sel = EX_wb_mux_select_b;
        m_ra = EX_alu_result_a; m_rb = EX_alu_result_b; m_pa = EX_pc_a; m_pb = EX_pc_b;
      end
      if (flush_all || (!MEM_stall && h)) begin
        {m_va, m_vb, m_wea, m_web} = '0;
      end else if (!MEM_stall) begin
        m_va  = EX_valid_a;
        m_vb  = EX_valid_b && !EX_kill_b;
        m_wea = EX_rf_we_a && m_va;
        m_web = EX_rf_we_b && m_vb;
      end
    end
  end

  // Every-cycle comparison; payload is only meaningful while its slot is valid.
  always @(negedge clk) begin
    #2;
    if (cmp_en) begin
      chk("m_valid_a", 32'(MEM_valid_a), 32'(m_va));
      chk("m_valid_b", 32'(MEM_valid_b), 32'(m_vb));
      chk("m_we_a", 32'(MEM_rf_we_a), 32'(m_wea));
      chk("m_we_b", 32'(MEM_rf_we_b), 32'(m_web));
      chk("m_ex_stall", 32'(EX_stall), 32'(MEM_stall || model_hz()));
      chk("m_cnt", interlock_cnt, m_cnt);
      if (m_va) begin
        chk("m_waddr_a", 32'(MEM_rf_waddr_a), 32'(m_wa));
        chk("m_res_a", MEM_alu_result_a, m_ra);
        chk("m_pc_a", MEM_pc_a, m_pa);
      end
      if (m_vb) begin
        chk("m_waddr_b", 32'(MEM_rf_waddr_b), 32'(m_wb));
        chk("m_sel_b", 32'(MEM_wb_mux_select_b), 32'(m_sel));
        chk("m_res_b", MEM_alu_result_b, m_rb);
        chk("m_pc_b", MEM_pc_b, m_pb);
      end
    end
  end

  task automatic idle();
    EX_valid_a = 0; EX_valid_b = 0; EX_rf_waddr_a = 0; EX_rf_waddr_b = 0;
    EX_rf_we_a = 0; EX_rf_we_b = 0; EX_wb_mux_select_b = 9'b1;
    EX_alu_result_a = 0; EX_alu_result_b = 0; EX_pc_a = 32'h1000; EX_pc_b = 32'h1004;
    EX_rf_raddr_a1 = 0; EX_rf_raddr_a2 = 0; EX_rf_raddr_b1 = 0; EX_rf_raddr_b2 = 0;
    EX_kill_b = 0; flush_all = 0; MEM_stall = 0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Present a slot-B producer writing r7 from the given source.
  task automatic present_b(input logic [8:0] sel, input logic [31:0] res);
    idle();
    EX_valid_b = 1; EX_rf_we_b = 1; EX_rf_waddr_b = 5'd7;
    EX_wb_mux_select_b = sel; EX_alu_result_b = res; EX_pc_b = 32'h2004;
  endtask

  initial begin
    idle();
    rst = 1;
    step(); step();
    cmp_en = 1;
    #1;
    chk("rst_valid_a", 32'(MEM_valid_a), 32'd0);
    chk("rst_we_b", 32'(MEM_rf_we_b), 32'd0);
    chk("rst_res_b", MEM_alu_result_b, 32'd0);
    chk("rst_cnt", interlock_cnt, 32'd0);
    chk("rst_ex_stall", 32'(EX_stall), 32'd0);
    rst = 0;

    // Plain flow through slot A
    EX_valid_a = 1; EX_rf_we_a = 1; EX_rf_waddr_a = 5'd5; EX_alu_result_a = 32'h1234;
    step(); #1;
    chk("flow_we_a", 32'(MEM_rf_we_a), 32'd1);
    chk("flow_waddr_a", 32'(MEM_rf_waddr_a), 32'd5);
    chk("flow_res_a", MEM_alu_result_a, 32'h1234);
    chk("flow_ex_stall", 32'(EX_stall), 32'd0);

    // Load-use on slot A source
    present_b(9'b000000010, 32'h5555);
    step();
    idle(); EX_valid_a = 1; EX_rf_raddr_a1 = 5'd7;
    #1 chk("lu_ex_stall", 32'(EX_stall), 32'd1);
    step(); #1;
    chk("lu_we_a", 32'(MEM_rf_we_a), 32'd0);
    chk("lu_we_b", 32'(MEM_rf_we_b), 32'd0);
    chk("lu_cnt", interlock_cnt, 32'd1);
    chk("lu_ex_stall_after", 32'(EX_stall), 32'd0);

    // No false hazard: ALU-sourced B
    present_b(9'b000000001, 32'h6666);
    step();
    idle(); EX_valid_a = 1; EX_rf_raddr_a1 = 5'd7;
    #1 chk("nf_alu_ex_stall", 32'(EX_stall), 32'd0);

    // No false hazard: matching sources in dead slots
    present_b(9'b000000010, 32'h7777);
    step();
    idle(); EX_rf_raddr_a1 = 5'd7; EX_rf_raddr_b2 = 5'd7;
    #1 chk("nf_invalid_ex_stall", 32'(EX_stall), 32'd0);
    EX_valid_b = 1;
    #1 chk("hz_slot_b_ex_stall", 32'(EX_stall), 32'd1);
    step(); #1 chk("hz_slot_b_cnt", interlock_cnt, 32'd2);

    // MEM_stall holds MEM and masks the hazard for 3 cycles
    present_b(9'b000000010, 32'hDEAD);
    step();
    idle(); MEM_stall = 1; EX_valid_a = 1; EX_rf_raddr_a1 = 5'd7; EX_alu_result_b = 32'hBEEF;
    for (int i = 0; i < 3; i++) begin
      step(); #1;
      chk("hold_res_b", MEM_alu_result_b, 32'hDEAD);
      chk("hold_cnt", interlock_cnt, 32'd2);
    end
    flush_all = 1;
    step(); #1;
    chk("flush_stall_valid_a", 32'(MEM_valid_a), 32'd0);
    chk("flush_stall_valid_b", 32'(MEM_valid_b), 32'd0);
    chk("flush_stall_we_a", 32'(MEM_rf_we_a), 32'd0);
    chk("flush_stall_we_b", 32'(MEM_rf_we_b), 32'd0);

    // Flush together with a hazard: no count
    present_b(9'b000000100, 32'h1111);
    step();
    idle(); EX_valid_a = 1; EX_rf_raddr_a2 = 5'd7; flush_all = 1;
    #1 chk("flush_hz_ex_stall", 32'(EX_stall), 32'd1);
    step(); #1;
    chk("flush_hz_cnt", interlock_cnt, 32'd2);
    chk("flush_hz_valid_b", 32'(MEM_valid_b), 32'd0);

    // Kill B
    idle(); EX_valid_a = 1; EX_valid_b = 1; EX_rf_we_a = 1; EX_rf_we_b = 1; EX_kill_b = 1;
    step(); #1;
    chk("kill_valid_a", 32'(MEM_valid_a), 32'd1);
    chk("kill_valid_b", 32'(MEM_valid_b), 32'd0);
    chk("kill_we_b", 32'(MEM_rf_we_b), 32'd0);

    // Reset in the middle of a bubble leaves no residual stall
    present_b(9'b000000010, 32'h2222);
    step();
    idle(); EX_valid_a = 1; EX_rf_raddr_a1 = 5'd7; rst = 1;
    step(); #1;
    chk("rst_bubble_ex_stall", 32'(EX_stall), 32'd0);
    chk("rst_bubble_cnt", interlock_cnt, 32'd0);
    rst = 0;

    // Counter saturation
    present_b(9'b000000010, 32'h3333);
    step();
    idle(); EX_valid_a = 1; EX_rf_raddr_a1 = 5'd7;
    force dut.cnt_q = 32'hFFFF_FFFE;
    m_cnt = 32'hFFFF_FFFE;
    #1 release dut.cnt_q;
    step(); #1 chk("sat_first", interlock_cnt, 32'hFFFF_FFFF);
    present_b(9'b000000010, 32'h4444);
    step();
    idle(); EX_valid_a = 1; EX_rf_raddr_a1 = 5'd7;
    step(); #1 chk("sat_hold", interlock_cnt, 32'hFFFF_FFFF);
    idle(); rst = 1;
    step(); #1 chk("sat_rst", interlock_cnt, 32'd0);
    rst = 0;
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
